rbus_muxnto1: RTL

- Parametrised N-input rbus packet multiplexer; successor of the fixed two-input mux.
- Takes N FIFO-head style rbus sources, arbitrates between pending packet headers, and forwards one whole packet at a time to a single rbus output.
- Arbitration is round-robin or fixed-priority. It honours the downstream short/long packet readiness.
- Adds a source-channel tag and a sticky framing-error flag. Sits between per-source rbus FIFOs and a shared rbus link.

---
 rtl/rbus_muxnto1_if.sv | 46 ++++
 rtl/rbus_muxnto1.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rbus_muxnto1_if.sv
// ---------------------------------------------------------------------------
// rbus_muxnto1_if
//   Bundles the N-source rbus inputs and the shared rbus output of the
//   N-to-1 packet multiplexer.
//
//   Source side (one lane per channel k, FIFO-head style):
//     i_stb[k]   head word valid
//     i_sof[k]   head word is a packet header
//     i_data     channel k head word in bits [72k+71:72k]
//     i_ack[k]   pop strobe, the head word is consumed while high
//   Link side:
//     o_stb      output word valid
//     o_sof      output word is a header
//     o_data     output word
//     o_rdy      downstream room: [0] short packet, [1] long packet
//     o_chn      source channel of the current output word
//     frm_err    sticky framing error
//
//   Modports: slave = multiplexer view, master = source/link environment.
// ---------------------------------------------------------------------------
interface rbus_muxnto1_if #(
   parameter int N = 4
);
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]      i_stb;
   logic [N-1:0]      i_sof;
   logic [N*72-1:0]   i_data;
   logic [N-1:0]      i_ack;
   logic              o_stb;
   logic              o_sof;
   logic [71:0]       o_data;
   logic [1:0]        o_rdy;
   logic [CW-1:0]     o_chn;
   logic              frm_err;

   modport slave (
      input  i_stb, i_sof, i_data, o_rdy,
      output i_ack, o_stb, o_sof, o_data, o_chn, frm_err
   );

   modport master (
      output i_stb, i_sof, i_data, o_rdy,
      input  i_ack, o_stb, o_sof, o_data, o_chn, frm_err
   );
endinterface

// File: rtl/rbus_muxnto1.sv
// ---------------------------------------------------------------------------
// rbus_muxnto1
//   Parametrised N-input rbus packet multiplexer. Arbitrates between pending
//   packet headers at the FIFO heads (round-robin or fixed priority), then
//   pops and forwards one whole packet from the winner. A packet is only
//   started when the downstream link reports room for its length class.
//
//   Ports:
//     clk   clock, single domain
//     rst   synchronous active-high reset
//     bus   rbus_muxnto1_if.slave (sources, link output, o_chn, frm_err)
//
//   Parameters:
//     N          number of input channels (2..16)
//     ARB_MODE   0 = round-robin, 1 = fixed priority (lowest index wins)
//     LEN_BIT    header data bit selecting packet length (1 = long)
//     SHORT_LEN  words in a short packet, header included
//     LONG_LEN   words in a long packet, header included
// ---------------------------------------------------------------------------
module rbus_muxnto1 #(
   parameter int N         = 4,
   parameter int ARB_MODE  = 0,
   parameter int LEN_BIT   = 39,
   parameter int SHORT_LEN = 2,
   parameter int LONG_LEN  = 9
) (
   input  logic          clk,
   input  logic          rst,
   rbus_muxnto1_if.slave bus
);
   localparam int         CW        = (N > 1) ? $clog2(N) : 1;
   localparam logic [4:0] SHORT_CNT = 5'(SHORT_LEN);
   localparam logic [4:0] LONG_CNT  = 5'(LONG_LEN);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t         state, state_nxt;

   // Per-channel view of the flat head-word bus.
   logic [71:0]    word [N];
   logic [N-1:0]   eligible;

   // Combinational grant encoder outputs.
   logic           arb_found;
   logic [CW-1:0]  arb_idx;
   logic           arb_len;

   // Packet context, latched at grant.
   logic [CW-1:0]  grant;
   logic [CW-1:0]  ptr;
   logic [4:0]     cnt;
   logic           first;
   logic [N-1:0]   ack;

   // Registered link outputs.
   logic           o_stb_q;
   logic           o_sof_q;
   logic [71:0]    o_data_q;
   logic [CW-1:0]  o_chn_q;
   logic           frm_err_q;

   logic           bad_word;

   // A channel may start only with a header at its head and room downstream
   // for that header's length class.
   always_comb begin : split_heads
      for (int k = 0; k < N; k++) begin
         word[k]     = bus.i_data[72*k +: 72];
         eligible[k] = bus.i_stb[k] & bus.i_sof[k] &
                       (word[k][LEN_BIT] ? bus.o_rdy[1] : bus.o_rdy[0]);
      end
   end

   // NOTE: every always_comb output is given a default before any branch so
   // that no path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin : grant_encoder
      arb_found = 1'b0;
      arb_idx   = '0;
      if (ARB_MODE == 1) begin
         // Scan high to low so the lowest eligible index is written last.
         for (int k = N - 1; k >= 0; k--) begin
            if (eligible[k]) begin
               arb_found = 1'b1;
               arb_idx   = CW'(k);
            end
         end
      end else begin
         // Scan from ptr+N down to ptr+1 so the channel right after the last
         // winner is written last and therefore has top priority.
         for (int i = N; i >= 1; i--) begin
            if (eligible[(int'(ptr) + i) % N]) begin
               arb_found = 1'b1;
               arb_idx   = CW'((int'(ptr) + i) % N);
            end
         end
      end
      arb_len = word[arb_idx][LEN_BIT];
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement or process order.
   always_ff @(posedge clk) begin : state_reg
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin : next_state
      state_nxt = state;
      case (state)
         IDLE: if (arb_found)   state_nxt = SEND;
         SEND: if (cnt == 5'd1) state_nxt = IDLE;
      endcase
   end

   // A word is malformed if the granted source has no data for this pop, or
   // shows a header anywhere but at the start of the packet.
   assign bad_word = !bus.i_stb[grant] || (bus.i_sof[grant] && !first);

   always_ff @(posedge clk) begin : datapath
      if (rst) begin
         grant     <= '0;
         ptr       <= CW'(N - 1);
         cnt       <= '0;
         first     <= 1'b0;
         ack       <= '0;
         o_stb_q   <= 1'b0;
         o_sof_q   <= 1'b0;
         o_data_q  <= '0;
         o_chn_q   <= '0;
         frm_err_q <= 1'b0;
      end else begin
         o_stb_q <= 1'b0;
         o_sof_q <= 1'b0;
         case (state)
            IDLE: begin
               if (arb_found) begin
                  grant <= arb_idx;
                  cnt   <= arb_len ? LONG_CNT : SHORT_CNT;
                  first <= 1'b1;
                  ack   <= {{(N-1){1'b0}}, 1'b1} << arb_idx;
                  if (ARB_MODE == 0) ptr <= arb_idx;
               end
            end
            SEND: begin
               // Each ack cycle forwards the popped word one cycle later;
               // framing faults are flagged but never shorten the packet.
               cnt      <= cnt - 5'd1;
               first    <= 1'b0;
               o_stb_q  <= 1'b1;
               o_sof_q  <= first;
               o_data_q <= word[grant];
               o_chn_q  <= grant;
               if (bad_word)     frm_err_q <= 1'b1;
               if (cnt == 5'd1)  ack       <= '0;
            end
         endcase
      end
   end

   assign bus.i_ack   = ack;
   assign bus.o_stb   = o_stb_q;
   assign bus.o_sof   = o_sof_q;
   assign bus.o_data  = o_data_q;
   assign bus.o_chn   = o_chn_q;
   assign bus.frm_err = frm_err_q;
endmodule
